// File: rtl/riscv_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_divider_pkg
// Description : Shared op and state encodings for the RV32M divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_divider_pkg;

    localparam int c_XLEN = 32;

    // Operation encodings as presented on div_op_i
    localparam logic [1:0] c_DIV_OP_DIV  = 2'd0;
    localparam logic [1:0] c_DIV_OP_DIVU = 2'd1;
    localparam logic [1:0] c_DIV_OP_REM  = 2'd2;
    localparam logic [1:0] c_DIV_OP_REMU = 2'd3;

    localparam logic [1:0] c_DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] c_DIV_ST_RUN  = 2'd1;
    localparam logic [1:0] c_DIV_ST_DONE = 2'd2;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == c_DIV_OP_DIV) || (op == c_DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == c_DIV_OP_REM) || (op == c_DIV_OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_divider.sv
`default_nettype none
// ============================================================================
// Module      : riscv_divider
// Description : Iterative restoring 32-bit divider for DIV/DIVU/REM/REMU,
//               one quotient bit per cycle, fixed latency, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_divider
    import riscv_divider_pkg::*;
#(
    parameter int DIV_LATENCY = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                div_valid_i,
    input  logic [1:0]          div_op_i,
    input  logic [c_XLEN-1:0]   div_a_i,
    input  logic [c_XLEN-1:0]   div_b_i,
    output logic                div_accept_o,
    input  logic                flush_i,
    output logic                div_valid_o,
    output logic [c_XLEN-1:0]   div_result_o
);

    localparam int                 c_CNT_W = $clog2(DIV_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV_LATENCY - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic [c_XLEN-1:0]  r_quo;
    logic [c_XLEN-1:0]  r_rem;
    logic [c_XLEN-1:0]  r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [c_CNT_W-1:0] r_count;
    logic               r_valid;
    logic [c_XLEN-1:0]  r_result;

    logic               w_signed;
    logic [c_XLEN-1:0]  w_a_mag;
    logic [c_XLEN-1:0]  w_b_mag;
    logic               w_neg_q_in;
    logic               w_neg_r_in;
    logic [c_XLEN:0]    w_rem_sh;
    logic               w_ge;
    logic [c_XLEN-1:0]  w_diff;
    logic [c_XLEN-1:0]  w_quo_fix;
    logic [c_XLEN-1:0]  w_rem_fix;
    logic [c_XLEN-1:0]  w_result;
    logic               w_last;

    // Operand capture: magnitudes for signed ops, raw values otherwise
    always_comb begin
        w_signed   = op_is_signed(div_op_i);
        w_a_mag    = (w_signed && div_a_i[c_XLEN-1]) ? (~div_a_i + 1'b1) : div_a_i;
        w_b_mag    = (w_signed && div_b_i[c_XLEN-1]) ? (~div_b_i + 1'b1) : div_b_i;
        // A zero divisor must yield all-ones quotient, so suppress its negation
        w_neg_q_in = w_signed && (div_a_i[c_XLEN-1] ^ div_b_i[c_XLEN-1])
                     && (div_b_i != '0);
        w_neg_r_in = w_signed && div_a_i[c_XLEN-1];
    end

    // One restoring step. The shifted remainder is below 2*divisor, so when
    // its top bit is set the subtraction always succeeds and fits in 32 bits.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[c_XLEN-1]};
        w_ge     = w_rem_sh[c_XLEN] || (w_rem_sh[c_XLEN-1:0] >= r_divisor);
        w_diff   = w_rem_sh[c_XLEN-1:0] - r_divisor;
        w_last   = (r_count == c_LAST);
    end

    always_comb begin
        w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        w_result  = op_is_rem(r_op) ? w_rem_fix : w_quo_fix;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_DIV_ST_IDLE;
            r_op      <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_result  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_DIV_ST_IDLE: begin
                    if (div_valid_i && !flush_i) begin
                        r_op      <= div_op_i;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= w_neg_q_in;
                        r_neg_r   <= w_neg_r_in;
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_state   <= c_DIV_ST_RUN;
                    end
                end
                c_DIV_ST_RUN: begin
                    if (flush_i) begin
                        r_state <= c_DIV_ST_IDLE;
                    end else begin
                        r_rem   <= w_ge ? w_diff : w_rem_sh[c_XLEN-1:0];
                        r_quo   <= {r_quo[c_XLEN-2:0], w_ge};
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_state <= c_DIV_ST_DONE;
                        end
                    end
                end
                c_DIV_ST_DONE: begin
                    r_state <= c_DIV_ST_IDLE;
                    if (!flush_i) begin
                        r_result <= w_result;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_DIV_ST_IDLE;
                end
            endcase
        end
    end

    assign div_accept_o = (r_state == c_DIV_ST_IDLE);
    assign div_valid_o  = r_valid;
    assign div_result_o = r_result;

endmodule
`default_nettype wire

// File: doc/riscv_divider.md
Name: riscv_divider

Overview:
- Iterative 32-bit integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the single-cycle combinational ALU in the execute stage.
- The ALU only covers add/sub, logic, shifts and compares. This block covers the multi-cycle divide path that the ALU cannot.
- Decode issues an operation over a valid/accept handshake. The result returns with a fixed latency, and writeback muxes it in.

Parameters:
- DIV_LATENCY, 32: number of iteration cycles in the RUN state. Fixed at one quotient bit per cycle; any other value is unsupported.

Ports:
- clk_i  in  1  core clock; all state changes on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- div_valid_i  in  1  decode presents an operation
- div_op_i  in  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU
- div_a_i  in  32  dividend (rs1)
- div_b_i  in  32  divisor (rs2)
- div_accept_o  out  1  unit idle and able to take an operation this cycle
- flush_i  in  1  pipeline flush; abandons any in-flight operation
- div_valid_o  out  1  one-cycle pulse; result valid
- div_result_o  out  32  quotient or remainder, as selected by the captured op

Behaviour:
- Reset (rst_i=1 at a clock edge) gives: state=IDLE, div_accept_o=1, div_valid_o=0, div_result_o=0, all internal registers cleared. rst_i has priority over every other input.
- States are IDLE, RUN and DONE.
- IDLE:
  - div_accept_o=1.
  - If div_valid_i=1 and flush_i=0, capture the op, |a|, |b| and the sign flags. Signed ops take the magnitude; unsigned ops use the raw value.
  - Clear the remainder register, set the iteration count to 0, go to RUN.
- RUN:
  - div_accept_o=0; div_valid_i is ignored.
  - Each cycle performs one restoring step. Shift {rem,quo} left by 1, bringing in the next dividend MSB. Then compute trial = rem - divisor (33-bit). If trial is non-negative, rem=trial and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - After DIV_LATENCY steps, go to DONE.
- DONE:
  - Apply the sign fixup. The quotient is negated when the signed op had differing operand signs. The remainder takes the sign of the dividend.
  - Register div_result_o and pulse div_valid_o=1 for exactly one cycle, then return to IDLE.
  - div_accept_o=0 in DONE.
- Latency: an operation accepted at edge N gives div_valid_o=1 during the cycle after edge N+33. That is 34 cycles from accept to the result pulse.
- Back-to-back: the earliest next accept is the cycle after the DONE pulse.
- div_result_o holds its value until the next DONE. It is not cleared on accept.
- Divide by zero (b=0) runs the full latency; there is no early out. Required results:
  - DIVU: 0xFFFFFFFF
  - DIV: 0xFFFFFFFF, regardless of the dividend's sign; the sign fixup must be suppressed
  - REM/REMU: the original div_a_i
- Signed overflow (a=0x80000000, b=0xFFFFFFFF):
  - DIV gives 0x80000000.
  - REM gives 0x00000000.
- flush_i=1 in RUN or DONE: go to IDLE next cycle. div_valid_o must not pulse for the flushed op. If the flush coincides with the DONE cycle, flush wins: div_valid_o=0.
- flush_i=1 together with div_valid_i=1 in IDLE: the operation is not captured.
- All arithmetic is unsigned 32/33-bit on magnitudes. Negation is two's complement, modulo 2^32.

Decomposition:
- Add the divide op encodings to the shared defs.v constants, alongside the existing ALU op codes: `DIV_OP_DIV, `DIV_OP_DIVU, `DIV_OP_REM, `DIV_OP_REMU.
- Add the state encodings to the same file: `DIV_ST_IDLE, `DIV_ST_RUN, `DIV_ST_DONE.
- Single module; a sub-module is not warranted. The restoring step is inline combinational logic in the same style as the ALU's staged shifter.

Test Plan:
- Reset, then DIVU a=100 b=7 -> accept seen, div_valid_o pulses 34 cycles later with result 14; REMU on the same operands -> 2.
- DIV a=0xFFFFFF9C (-100) b=7 -> 0xFFFFFFF2 (-14); REM on the same operands -> 0xFFFFFFFE (-2).
- Divide by zero, a=0x80000001 b=0: DIV -> 0xFFFFFFFF, DIVU -> 0xFFFFFFFF, REM -> 0x80000001, REMU -> 0x80000001.
- Overflow, a=0x80000000 b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0; DIVU -> 0, REMU -> 0x80000000.
- Assert flush_i at iteration 10, and separately on the DONE cycle -> no div_valid_o pulse in either case; accept reasserts the next cycle; a following DIVU 9/3 -> 3.
- Assert rst_i mid-RUN, then issue DIVU 0xFFFFFFFF/1 -> no stale pulse from the interrupted op; result 0xFFFFFFFF after 34 cycles; holding div_valid_i high during RUN is ignored.
